// File: rtl/dispense_pkg.sv
// rtl/dispense_pkg.sv - shared state enums, timeout width and coin-select constants for the dispense sequencer
//
// Contents:
//   state_t        sequencer states (IDLE, LOAD, TKT, TKT_WAIT, COIN, COIN_WAIT, DONE, FAULT)
//   ch_phase_t     handshake channel phases
//   TO_W           width of every handshake timeout counter (covers TIMEOUT up to 65535)
//   COIN_SEL_BIG / COIN_SEL_SMALL  values driven on coin_sel
//   sat_add16      saturating 16-bit add used by the lifetime totals
package dispense_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        TKT,
        TKT_WAIT,
        COIN,
        COIN_WAIT,
        DONE,
        FAULT
    } state_t;

    // CH_ARM waits for an ack left high by the far end before a new req may rise.
    typedef enum logic [1:0] {
        CH_IDLE,
        CH_ARM,
        CH_REQ,
        CH_REL
    } ch_phase_t;

    localparam int TO_W = 16;

    localparam logic COIN_SEL_BIG   = 1'b1;
    localparam logic COIN_SEL_SMALL = 1'b0;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/dispense_sequencer_if.sv
// rtl/dispense_sequencer_if.sv - sale-controller, printer and hopper signals of the dispense sequencer
//
// Signals:
//   start, ticketType[1:0], ticketCount[1:0], moneyReturn[7:0], clr   sale controller -> sequencer
//   tkt_req, tkt_type[1:0] / tkt_ack                                   sequencer <-> ticket printer
//   coin_req, coin_sel / coin_ack                                      sequencer <-> coin hopper
//   busy, done, fault, remain[7:0]                                     sequencer status
// Modports:
//   slave   the sequencer's view
//   master  the surrounding system's view (controller and drivers)
interface dispense_sequencer_if;

    logic       start;
    logic [1:0] ticketType;
    logic [1:0] ticketCount;
    logic [7:0] moneyReturn;
    logic       clr;

    logic       tkt_req;
    logic [1:0] tkt_type;
    logic       tkt_ack;

    logic       coin_req;
    logic       coin_sel;
    logic       coin_ack;

    logic       busy;
    logic       done;
    logic       fault;
    logic [7:0] remain;

    modport slave (
        input  start, ticketType, ticketCount, moneyReturn, clr, tkt_ack, coin_ack,
        output tkt_req, tkt_type, coin_req, coin_sel, busy, done, fault, remain
    );

    modport master (
        output start, ticketType, ticketCount, moneyReturn, clr, tkt_ack, coin_ack,
        input  tkt_req, tkt_type, coin_req, coin_sel, busy, done, fault, remain
    );

endinterface

// File: rtl/hs_channel.sv
// rtl/hs_channel.sv - one 4-phase req/ack item transfer with a per-phase timeout
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active-low
//   go        in   1-cycle request to transfer one item (only honoured when idle)
//   ack       in   acknowledge from the far end
//   req       out  request to the far end
//   accepted  out  1-cycle pulse: ack sampled high, req dropped
//   released  out  1-cycle pulse: ack sampled low again, item complete
//   timeout   out  1-cycle pulse: a phase lasted TIMEOUT cycles; channel returns idle with req low
module hs_channel
    import dispense_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  logic ack,
    output logic req,
    output logic accepted,
    output logic released,
    output logic timeout
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

    ch_phase_t       phase;
    logic [TO_W-1:0] cnt;

    // cnt is reloaded on each phase entry; a phase that sees LIMIT without
    // progress has been waiting TIMEOUT cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase    <= CH_IDLE;
            cnt      <= '0;
            req      <= 1'b0;
            accepted <= 1'b0;
            released <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            accepted <= 1'b0;
            released <= 1'b0;
            timeout  <= 1'b0;
            case (phase)
                CH_IDLE: begin
                    if (go) begin
                        cnt <= '0;
                        if (ack) begin
                            phase <= CH_ARM;
                        end else begin
                            phase <= CH_REQ;
                            req   <= 1'b1;
                        end
                    end
                end
                CH_ARM: begin
                    if (!ack) begin
                        phase <= CH_REQ;
                        req   <= 1'b1;
                        cnt   <= '0;
                    end else if (cnt == LIMIT) begin
                        phase   <= CH_IDLE;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + TO_W'(1);
                    end
                end
                CH_REQ: begin
                    if (ack) begin
                        phase    <= CH_REL;
                        req      <= 1'b0;
                        accepted <= 1'b1;
                        cnt      <= '0;
                    end else if (cnt == LIMIT) begin
                        phase   <= CH_IDLE;
                        req     <= 1'b0;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + TO_W'(1);
                    end
                end
                CH_REL: begin
                    if (!ack) begin
                        phase    <= CH_IDLE;
                        released <= 1'b1;
                    end else if (cnt == LIMIT) begin
                        phase   <= CH_IDLE;
                        timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + TO_W'(1);
                    end
                end
                default: begin
                    phase <= CH_IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/dispense_sequencer.sv
// rtl/dispense_sequencer.sv - pays out tickets then greedy two-denomination change over req/ack handshakes
//
// Parameters:
//   COIN_BIG    value of the large coin (coin_sel=1), must exceed COIN_SMALL
//   COIN_SMALL  value of the small coin (coin_sel=0)
//   TIMEOUT     cycles allowed per handshake phase before FAULT (1..65535)
// Ports:
//   clk              in   system clock, rising edge
//   rst              in   asynchronous reset, active-low
//   bus              slave modport of dispense_sequencer_if (sale inputs, printer/hopper handshakes, status)
//   log_tickets[15]  out  saturating lifetime count of acked tickets   (only with DISPENSE_LOG_EN)
//   log_change[15]   out  saturating lifetime value of acked coins     (only with DISPENSE_LOG_EN)
// Build option:
//   DISPENSE_LOG_EN  adds the lifetime totals above; cleared only by rst
module dispense_sequencer
    import dispense_pkg::*;
#(
    parameter int COIN_BIG   = 5,
    parameter int COIN_SMALL = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    dispense_sequencer_if.slave  bus
`ifdef DISPENSE_LOG_EN
    ,
    output logic [15:0]          log_tickets,
    output logic [15:0]          log_change
`endif
);

    localparam logic [7:0] BIG8   = 8'(COIN_BIG);
    localparam logic [7:0] SMALL8 = 8'(COIN_SMALL);

    state_t     state;
    logic [1:0] count;
    logic [7:0] remain_q;
    logic       issued;       // the current item's go has been handed to its channel
    logic [1:0] tkt_type_q;
    logic       coin_sel_q;
    logic       busy_q;
    logic       done_q;
    logic       fault_q;

    logic       tkt_go;
    logic       coin_go;
    logic [7:0] coin_value;

    logic       t_req, t_accepted, t_released, t_timeout;
    logic       c_req, c_accepted, c_released, c_timeout;

    assign tkt_go     = (state == TKT) && (count != 2'd0) && !issued;
    assign coin_go    = (state == COIN) && (remain_q != 8'd0) && (remain_q >= SMALL8) && !issued;
    assign coin_value = (coin_sel_q == COIN_SEL_BIG) ? BIG8 : SMALL8;

    hs_channel #(.TIMEOUT(TIMEOUT)) u_tkt_ch (
        .clk      (clk),
        .rst      (rst),
        .go       (tkt_go),
        .ack      (bus.tkt_ack),
        .req      (t_req),
        .accepted (t_accepted),
        .released (t_released),
        .timeout  (t_timeout)
    );

    hs_channel #(.TIMEOUT(TIMEOUT)) u_coin_ch (
        .clk      (clk),
        .rst      (rst),
        .go       (coin_go),
        .ack      (bus.coin_ack),
        .req      (c_req),
        .accepted (c_accepted),
        .released (c_released),
        .timeout  (c_timeout)
    );

    // Inputs are captured on the start edge so the controller may change
    // them afterwards; LOAD is the one-cycle settle before the ticket phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= 2'd0;
            remain_q   <= 8'd0;
            issued     <= 1'b0;
            tkt_type_q <= 2'd0;
            coin_sel_q <= COIN_SEL_SMALL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (t_timeout || c_timeout) begin
                // remain is left as-is so the shortfall stays visible in FAULT
                state   <= FAULT;
                fault_q <= 1'b1;
                issued  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start) begin
                            tkt_type_q <= bus.ticketType;
                            count      <= bus.ticketCount;
                            remain_q   <= bus.moneyReturn;
                            issued     <= 1'b0;
                            busy_q     <= 1'b1;
                            state      <= LOAD;
                        end
                    end
                    LOAD: begin
                        state <= TKT;
                    end
                    TKT: begin
                        if (t_accepted) begin
                            count <= count - 2'd1;
                            state <= TKT_WAIT;
                        end else if (count == 2'd0) begin
                            state <= COIN;
                        end else if (tkt_go) begin
                            issued <= 1'b1;
                        end
                    end
                    TKT_WAIT: begin
                        if (t_released) begin
                            issued <= 1'b0;
                            state  <= TKT;
                        end
                    end
                    COIN: begin
                        if (c_accepted) begin
                            // coin_sel was chosen against remain, so this cannot underflow
                            remain_q <= remain_q - coin_value;
                            state    <= COIN_WAIT;
                        end else if (remain_q == 8'd0) begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else if (remain_q < SMALL8) begin
                            // change not payable with the smallest coin
                            fault_q <= 1'b1;
                            state   <= FAULT;
                        end else if (coin_go) begin
                            issued     <= 1'b1;
                            coin_sel_q <= (remain_q >= BIG8) ? COIN_SEL_BIG : COIN_SEL_SMALL;
                        end
                    end
                    COIN_WAIT: begin
                        if (c_released) begin
                            issued <= 1'b0;
                            state  <= COIN;
                        end
                    end
                    DONE: begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                    FAULT: begin
                        // clr has priority; a start seen here is simply dropped
                        if (bus.clr) begin
                            fault_q  <= 1'b0;
                            busy_q   <= 1'b0;
                            remain_q <= 8'd0;
                            count    <= 2'd0;
                            issued   <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                    default: begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef DISPENSE_LOG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            log_tickets <= 16'd0;
            log_change  <= 16'd0;
        end else begin
            if (t_accepted) begin
                log_tickets <= sat_add16(log_tickets, 16'd1);
            end
            if (c_accepted) begin
                log_change <= sat_add16(log_change, {8'd0, coin_value});
            end
        end
    end
`endif

    assign bus.tkt_req  = t_req;
    assign bus.tkt_type = tkt_type_q;
    assign bus.coin_req = c_req;
    assign bus.coin_sel = coin_sel_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.fault    = fault_q;
    assign bus.remain   = remain_q;

endmodule

// File: tb/tb_dispense_sequencer.sv
// tb/tb_dispense_sequencer.sv - directed self-checking bench for dispense_sequencer
module tb_dispense_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    dispense_sequencer_if bus();

`ifdef DISPENSE_LOG_EN
    logic [15:0] log_tickets;
    logic [15:0] log_change;
`endif

    dispense_sequencer #(
        .COIN_BIG   (5),
        .COIN_SMALL (1),
        .TIMEOUT    (255)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus)
`ifdef DISPENSE_LOG_EN
        ,
        .log_tickets (log_tickets),
        .log_change  (log_change)
`endif
    );

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    bit tkt_auto  = 1'b0;
    bit coin_auto = 1'b0;

    int         tkt_reqs    = 0;
    int         coin_reqs   = 0;
    int         done_pulses = 0;
    logic [1:0] last_type   = 2'd0;
    logic       coin_sels[$];
    logic [7:0] coin_rems[$];
    logic       prev_t = 1'b0;
    logic       prev_c = 1'b0;

    // Printer/hopper models: ack follows req half a cycle later.
    initial forever begin
        @(negedge clk);
        bus.tkt_ack  = tkt_auto & (bus.tkt_req === 1'b1);
        bus.coin_ack = coin_auto & (bus.coin_req === 1'b1);
    end

    // Record each request's rising edge and every done cycle.
    initial forever begin
        @(posedge clk);
        #1;
        if (bus.tkt_req === 1'b1 && prev_t !== 1'b1) begin
            tkt_reqs++;
            last_type = bus.tkt_type;
        end
        if (bus.coin_req === 1'b1 && prev_c !== 1'b1) begin
            coin_reqs++;
            coin_sels.push_back(bus.coin_sel);
            coin_rems.push_back(bus.remain);
        end
        if (bus.done === 1'b1) done_pulses++;
        prev_t = bus.tkt_req;
        prev_c = bus.coin_req;
    end

    function automatic logic sel_at(input int idx);
        if (idx < coin_sels.size()) return coin_sels[idx];
        return 1'bx;
    endfunction

    function automatic logic [7:0] rem_at(input int idx);
        if (idx < coin_rems.size()) return coin_rems[idx];
        return 8'hxx;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [1:0] ty, input logic [1:0] cnt, input logic [7:0] money);
        @(negedge clk);
        bus.ticketType  = ty;
        bus.ticketCount = cnt;
        bus.moneyReturn = money;
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic wait_coin_req(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            @(negedge clk);
            if (bus.coin_req === 1'b1) ok = 1'b1;
        end
    endtask

    initial begin
        bit ok;
        int t0, c0, d0, q0, cyc;

        bus.start       = 1'b0;
        bus.ticketType  = 2'd0;
        bus.ticketCount = 2'd0;
        bus.moneyReturn = 8'd0;
        bus.clr         = 1'b0;
        bus.tkt_ack     = 1'b0;
        bus.coin_ack    = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tkt_req",  bus.tkt_req,  0);
        chk("rst_coin_req", bus.coin_req, 0);
        chk("rst_busy",     bus.busy,     0);
        chk("rst_done",     bus.done,     0);
        chk("rst_fault",    bus.fault,    0);
        chk("rst_remain",   bus.remain,   0);
        chk("rst_coin_sel", bus.coin_sel, 0);
        chk("rst_tkt_type", bus.tkt_type, 0);
        rst = 1'b1;
        tkt_auto  = 1'b1;
        coin_auto = 1'b1;
        repeat (2) @(negedge clk);

        // 3 tickets, 12 change: coins 5,5,1,1
        t0 = tkt_reqs; c0 = coin_reqs; d0 = done_pulses; q0 = coin_sels.size();
        pulse_start(2'd2, 2'd3, 8'd12);
        wait_done(400, ok);
        chk("t1_done_seen", ok, 1);
        repeat (3) @(negedge clk);
        chk("t1_tkt_count",  tkt_reqs - t0, 3);
        chk("t1_tkt_type",   last_type, 2);
        chk("t1_coin_count", coin_reqs - c0, 4);
        chk("t1_sel0", sel_at(q0),     1);
        chk("t1_sel1", sel_at(q0 + 1), 1);
        chk("t1_sel2", sel_at(q0 + 2), 0);
        chk("t1_sel3", sel_at(q0 + 3), 0);
        chk("t1_rem0", rem_at(q0),     12);
        chk("t1_rem1", rem_at(q0 + 1), 7);
        chk("t1_rem2", rem_at(q0 + 2), 2);
        chk("t1_rem3", rem_at(q0 + 3), 1);
        chk("t1_remain_end", bus.remain, 0);
        chk("t1_done_pulses", done_pulses - d0, 1);
        chk("t1_busy_end", bus.busy, 0);

        // 0 tickets, 0 change: LOAD, TKT, COIN, then done in DONE
        t0 = tkt_reqs; c0 = coin_reqs;
        pulse_start(2'd1, 2'd0, 8'd0);
        chk("t2_busy_load", bus.busy, 1);
        chk("t2_done_load", bus.done, 0);
        @(negedge clk);
        chk("t2_busy_tkt", bus.busy, 1);
        chk("t2_done_tkt", bus.done, 0);
        @(negedge clk);
        chk("t2_busy_coin", bus.busy, 1);
        chk("t2_done_coin", bus.done, 0);
        @(negedge clk);
        chk("t2_done_3cyc", bus.done, 1);
        chk("t2_busy_done", bus.busy, 1);
        @(negedge clk);
        chk("t2_done_after", bus.done, 0);
        chk("t2_busy_after", bus.busy, 0);
        chk("t2_no_tkt",  tkt_reqs - t0, 0);
        chk("t2_no_coin", coin_reqs - c0, 0);

        // printer never acks: FAULT after the timeout, then clr beats start
        tkt_auto = 1'b0;
        pulse_start(2'd0, 2'd1, 8'd7);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 1; i <= 400 && !ok; i++) begin
            @(negedge clk);
            if (bus.fault === 1'b1) begin
                ok  = 1'b1;
                cyc = i;
            end
        end
        chk("t3_fault_seen",  ok, 1);
        chk("t3_fault_cycle", cyc, 258);
        chk("t3_tkt_req_low", bus.tkt_req, 0);
        chk("t3_remain_frozen", bus.remain, 7);
        chk("t3_busy_fault", bus.busy, 1);
        pulse_start(2'd0, 2'd0, 8'd3);
        @(negedge clk);
        chk("t3_start_ignored", bus.fault, 1);
        chk("t3_remain_still", bus.remain, 7);
        bus.clr   = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.clr   = 1'b0;
        bus.start = 1'b0;
        chk("t3_clr_fault", bus.fault, 0);
        chk("t3_clr_busy", bus.busy, 0);
        chk("t3_clr_remain", bus.remain, 0);
        @(negedge clk);
        chk("t3_start_dropped", bus.busy, 0);
        tkt_auto = 1'b1;

        // second start during coin payout of 10 is ignored
        t0 = tkt_reqs; c0 = coin_reqs; d0 = done_pulses; q0 = coin_sels.size();
        pulse_start(2'd0, 2'd0, 8'd10);
        wait_coin_req(50, ok);
        chk("t4_coin_started", ok, 1);
        pulse_start(2'd1, 2'd2, 8'd3);
        wait_done(200, ok);
        chk("t4_done_seen", ok, 1);
        repeat (30) @(negedge clk);
        chk("t4_coin_count", coin_reqs - c0, 2);
        chk("t4_sel0", sel_at(q0),     1);
        chk("t4_sel1", sel_at(q0 + 1), 1);
        chk("t4_no_tkt", tkt_reqs - t0, 0);
        chk("t4_done_once", done_pulses - d0, 1);
        chk("t4_idle_after", bus.busy, 0);

        // asynchronous reset while a coin request is outstanding
        pulse_start(2'd0, 2'd0, 8'd10);
        wait_coin_req(50, ok);
        chk("t5_coin_req_seen", ok, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t5_async_coin_req", bus.coin_req, 0);
        chk("t5_async_busy", bus.busy, 0);
        chk("t5_async_remain", bus.remain, 0);
        @(negedge clk);
        rst = 1'b1;
        t0 = tkt_reqs; c0 = coin_reqs; d0 = done_pulses; q0 = coin_sels.size();
        pulse_start(2'd3, 2'd1, 8'd6);
        wait_done(200, ok);
        chk("t5_done_seen", ok, 1);
        repeat (3) @(negedge clk);
        chk("t5_tkt_count", tkt_reqs - t0, 1);
        chk("t5_tkt_type", last_type, 3);
        chk("t5_coin_count", coin_reqs - c0, 2);
        chk("t5_sel0", sel_at(q0),     1);
        chk("t5_sel1", sel_at(q0 + 1), 0);
        chk("t5_rem1", rem_at(q0 + 1), 1);
        chk("t5_done_once", done_pulses - d0, 1);

        // two sales after a fresh reset: 2/6 then 3/9
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        d0 = done_pulses; t0 = tkt_reqs;
        pulse_start(2'd0, 2'd2, 8'd6);
        wait_done(200, ok);
        chk("t6_sale1_done", ok, 1);
        pulse_start(2'd1, 2'd3, 8'd9);
        wait_done(200, ok);
        chk("t6_sale2_done", ok, 1);
        repeat (3) @(negedge clk);
        chk("t6_tickets", tkt_reqs - t0, 5);
        chk("t6_done_pulses", done_pulses - d0, 2);
        chk("t6_remain", bus.remain, 0);
`ifdef DISPENSE_LOG_EN
        chk("t6_log_tickets", log_tickets, 5);
        chk("t6_log_change", log_change, 15);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
